// File: rtl/bp_cce_lce_req_responder.sv
// bp_cce_lce_req_responder
//   CCE-side responder for a single dcache LCE. It services one cached or
//   uncached-load miss at a time and lets up to max_uc_wr_p uncached stores
//   run ahead to memory.
//
//   Handling a miss:
//     1. Write back the LRU victim if it is dirty.
//     2. Fetch the block (or the uncached word) from memory.
//     3. Return the data to the LCE.
//     4. For cached fills, wait for the coh_ack before taking the next request.
//
// Message layouts (packed, MSB first):
//   lce_req  : {msg_type[1:0], lru_dirty, lru_way_id, uc_size[1:0], addr, data[dword]}
//              msg_type 0=rd 1=wr 2=uc_rd 3=uc_wr
//   lce_resp : {msg_type[1:0], addr, data[block]}
//              msg_type 0=coh_ack 1=resp_wb 2=resp_null_wb
//   lce_cmd  : {msg_type[1:0], src_id, way_id, state[1:0], addr, data[block]}
//              msg_type 0=wb 1=data 2=uc_data; state 0=I 1=S 2=E 3=M
//   mem msg  : {msg_type[1:0], size[2:0], addr, data[block]}
//              msg_type 0=rd 1=wr 2=uc_rd 3=uc_wr
//              size 0..3 = 1/2/4/8 bytes, 6 = whole block
//
// Ports:
//   clk_i, reset_i                   clock, asynchronous active-high reset
//   cce_id_i                         src_id placed in every LCE command
//   lce_req_i/_v_i/_yumi_o           LCE requests (valid -> yumi)
//   lce_resp_i/_v_i/_yumi_o          LCE responses (valid -> yumi)
//   lce_cmd_o/_v_o/_ready_i          LCE commands (valid -> ready)
//   mem_cmd_o/_v_o/_ready_i          memory commands (valid -> ready)
//   mem_resp_i/_v_i/_yumi_o          memory responses (valid -> yumi)
module bp_cce_lce_req_responder #(
    parameter int paddr_width_p  = 40,
    parameter int cce_id_width_p = 3,
    parameter int way_id_width_p = 3,
    parameter int dword_width_p  = 64,
    parameter int block_width_p  = 512,
    parameter int max_uc_wr_p    = 4,
    localparam int lce_cce_req_width_lp  = 2 + 1 + way_id_width_p + 2 + paddr_width_p + dword_width_p,
    localparam int lce_cce_resp_width_lp = 2 + paddr_width_p + block_width_p,
    localparam int lce_cmd_width_lp      = 2 + cce_id_width_p + way_id_width_p + 2 + paddr_width_p + block_width_p,
    localparam int cce_mem_msg_width_lp  = 2 + 3 + paddr_width_p + block_width_p
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [cce_id_width_p-1:0]        cce_id_i,

    input  logic [lce_cce_req_width_lp-1:0]  lce_req_i,
    input  logic                             lce_req_v_i,
    output logic                             lce_req_yumi_o,

    input  logic [lce_cce_resp_width_lp-1:0] lce_resp_i,
    input  logic                             lce_resp_v_i,
    output logic                             lce_resp_yumi_o,

    output logic [lce_cmd_width_lp-1:0]      lce_cmd_o,
    output logic                             lce_cmd_v_o,
    input  logic                             lce_cmd_ready_i,

    output logic [cce_mem_msg_width_lp-1:0]  mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,

    input  logic [cce_mem_msg_width_lp-1:0]  mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o
);

    localparam int cnt_w_lp   = $clog2(max_uc_wr_p + 1);
    localparam int blk_off_lp = $clog2(block_width_p / 8);

    localparam logic [1:0] REQ_RD     = 2'd0;
    localparam logic [1:0] REQ_WR     = 2'd1;
    localparam logic [1:0] REQ_UC_RD  = 2'd2;
    localparam logic [1:0] REQ_UC_WR  = 2'd3;

    localparam logic [1:0] RESP_COH_ACK = 2'd0;
    localparam logic [1:0] RESP_WB      = 2'd1;
    localparam logic [1:0] RESP_NULL_WB = 2'd2;

    localparam logic [1:0] CMD_WB      = 2'd0;
    localparam logic [1:0] CMD_DATA    = 2'd1;
    localparam logic [1:0] CMD_UC_DATA = 2'd2;

    localparam logic [1:0] COH_I = 2'd0;
    localparam logic [1:0] COH_E = 2'd2;

    localparam logic [1:0] MEM_RD    = 2'd0;
    localparam logic [1:0] MEM_WR    = 2'd1;
    localparam logic [1:0] MEM_UC_RD = 2'd2;
    localparam logic [1:0] MEM_UC_WR = 2'd3;

    localparam logic [2:0] SIZE_BLOCK = 3'd6;

    typedef struct packed {
        logic [1:0]                msg_type;
        logic                      lru_dirty;
        logic [way_id_width_p-1:0] lru_way_id;
        logic [1:0]                uc_size;
        logic [paddr_width_p-1:0]  addr;
        logic [dword_width_p-1:0]  data;
    } lce_req_s;

    typedef struct packed {
        logic [1:0]               msg_type;
        logic [paddr_width_p-1:0] addr;
        logic [block_width_p-1:0] data;
    } lce_resp_s;

    typedef struct packed {
        logic [1:0]                msg_type;
        logic [cce_id_width_p-1:0] src_id;
        logic [way_id_width_p-1:0] way_id;
        logic [1:0]                state;
        logic [paddr_width_p-1:0]  addr;
        logic [block_width_p-1:0]  data;
    } lce_cmd_s;

    typedef struct packed {
        logic [1:0]               msg_type;
        logic [2:0]               size;
        logic [paddr_width_p-1:0] addr;
        logic [block_width_p-1:0] data;
    } mem_msg_s;

    typedef enum logic [3:0] {
        e_READY,
        e_SEND_WB,
        e_WAIT_WB,
        e_MEM_WB,
        e_MEM_RD,
        e_MEM_UC_RD,
        e_WAIT_MEM,
        e_SEND_DATA,
        e_WAIT_ACK
    } state_e;

    function automatic logic [paddr_width_p-1:0] block_align(input logic [paddr_width_p-1:0] a);
        return {a[paddr_width_p-1:blk_off_lp], {blk_off_lp{1'b0}}};
    endfunction

    // Saturating up/down count of uncached stores awaiting a memory ack.
    function automatic logic [cnt_w_lp-1:0] uc_cnt_next(input logic [cnt_w_lp-1:0] cnt,
                                                        input logic inc, input logic dec);
        if (inc && !dec && (cnt < cnt_w_lp'(max_uc_wr_p)))
            return cnt + cnt_w_lp'(1);
        if (dec && !inc && (cnt != '0))
            return cnt - cnt_w_lp'(1);
        return cnt;
    endfunction

    lce_req_s  req;
    lce_resp_s resp;
    mem_msg_s  mresp;
    lce_cmd_s  cmd_out;
    mem_msg_s  mcmd_out;

    assign req   = lce_req_i;
    assign resp  = lce_resp_i;
    assign mresp = mem_resp_i;
    assign lce_cmd_o = cmd_out;
    assign mem_cmd_o = mcmd_out;

    state_e                    state_q;
    logic [cnt_w_lp-1:0]       uc_wr_cnt_q;
    logic [paddr_width_p-1:0]  addr_q;
    logic [paddr_width_p-1:0]  wb_addr_q;
    logic [way_id_width_p-1:0] way_q;
    logic [2:0]                size_q;
    logic                      uc_q;
    logic [block_width_p-1:0]  data_q;

    logic uc_wr_room;
    logic read_resp_ok;
    logic mem_wr_ack;
    logic uc_wr_inc;
    logic uc_wr_dec;

    // Only the memory response type and data are acted on.
    logic unused_mresp_fields;
    assign unused_mresp_fields = ^{mresp.size, mresp.addr};

    assign uc_wr_room   = (uc_wr_cnt_q < cnt_w_lp'(max_uc_wr_p));
    assign mem_wr_ack   = (mresp.msg_type == MEM_WR) || (mresp.msg_type == MEM_UC_WR);
    assign read_resp_ok = (state_q == e_WAIT_MEM)
                       && (mresp.msg_type == (uc_q ? MEM_UC_RD : MEM_RD));
    assign uc_wr_inc    = lce_req_yumi_o && (state_q == e_READY) && (req.msg_type == REQ_UC_WR);
    assign uc_wr_dec    = mem_resp_yumi_o && (mresp.msg_type == MEM_UC_WR);

    always_comb begin
        lce_req_yumi_o  = 1'b0;
        lce_resp_yumi_o = 1'b0;
        lce_cmd_v_o     = 1'b0;
        mem_cmd_v_o     = 1'b0;
        cmd_out         = '0;
        mcmd_out        = '0;
        cmd_out.src_id  = cce_id_i;

        // Write acks (writeback or uncached store) are drained in any state;
        // read data is only taken while a fill is outstanding.
        mem_resp_yumi_o = mem_resp_v_i && (mem_wr_ack || read_resp_ok);

        case (state_q)
            e_READY: begin
                if (lce_req_v_i) begin
                    case (req.msg_type)
                        REQ_UC_WR: begin
                            // Offer the store only when a slot is free so memory
                            // never takes a command we did not consume.
                            if (uc_wr_room) begin
                                mem_cmd_v_o       = 1'b1;
                                mcmd_out.msg_type = MEM_UC_WR;
                                mcmd_out.size     = {1'b0, req.uc_size};
                                mcmd_out.addr     = req.addr;
                                mcmd_out.data     = {{(block_width_p-dword_width_p){1'b0}}, req.data};
                                lce_req_yumi_o    = mem_cmd_ready_i;
                            end
                        end
                        REQ_UC_RD: lce_req_yumi_o = 1'b1;
                        // Cached misses wait for all uncached stores to drain.
                        default:   lce_req_yumi_o = (uc_wr_cnt_q == '0);
                    endcase
                end
            end
            e_SEND_WB: begin
                lce_cmd_v_o      = 1'b1;
                cmd_out.msg_type = CMD_WB;
                cmd_out.way_id   = way_q;
                cmd_out.state    = COH_I;
                cmd_out.addr     = addr_q;
            end
            e_WAIT_WB: begin
                lce_resp_yumi_o = lce_resp_v_i
                               && ((resp.msg_type == RESP_WB) || (resp.msg_type == RESP_NULL_WB));
            end
            e_MEM_WB: begin
                mem_cmd_v_o       = 1'b1;
                mcmd_out.msg_type = MEM_WR;
                mcmd_out.size     = SIZE_BLOCK;
                mcmd_out.addr     = wb_addr_q;
                mcmd_out.data     = data_q;
            end
            e_MEM_RD: begin
                mem_cmd_v_o       = 1'b1;
                mcmd_out.msg_type = MEM_RD;
                mcmd_out.size     = SIZE_BLOCK;
                mcmd_out.addr     = block_align(addr_q);
            end
            e_MEM_UC_RD: begin
                mem_cmd_v_o       = 1'b1;
                mcmd_out.msg_type = MEM_UC_RD;
                mcmd_out.size     = size_q;
                mcmd_out.addr     = addr_q;
            end
            e_SEND_DATA: begin
                lce_cmd_v_o  = 1'b1;
                cmd_out.addr = addr_q;
                if (uc_q) begin
                    cmd_out.msg_type = CMD_UC_DATA;
                    cmd_out.state    = COH_I;
                    cmd_out.data     = {{(block_width_p-dword_width_p){1'b0}}, data_q[dword_width_p-1:0]};
                end else begin
                    // Single LCE: every cached fill is granted exclusive.
                    cmd_out.msg_type = CMD_DATA;
                    cmd_out.way_id   = way_q;
                    cmd_out.state    = COH_E;
                    cmd_out.data     = data_q;
                end
            end
            e_WAIT_ACK: begin
                lce_resp_yumi_o = lce_resp_v_i && (resp.msg_type == RESP_COH_ACK)
                               && (block_align(resp.addr) == block_align(addr_q));
            end
            default: ;
        endcase

        // Handshake outputs drop as soon as reset is asserted.
        if (reset_i) begin
            lce_req_yumi_o  = 1'b0;
            lce_resp_yumi_o = 1'b0;
            lce_cmd_v_o     = 1'b0;
            mem_cmd_v_o     = 1'b0;
            mem_resp_yumi_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_READY;
            uc_wr_cnt_q <= '0;
            addr_q      <= '0;
            wb_addr_q   <= '0;
            way_q       <= '0;
            size_q      <= '0;
            uc_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            uc_wr_cnt_q <= uc_cnt_next(uc_wr_cnt_q, uc_wr_inc, uc_wr_dec);

            case (state_q)
                e_READY: begin
                    if (lce_req_yumi_o && (req.msg_type != REQ_UC_WR)) begin
                        addr_q <= req.addr;
                        way_q  <= req.lru_way_id;
                        if (req.msg_type == REQ_UC_RD) begin
                            uc_q    <= 1'b1;
                            size_q  <= {1'b0, req.uc_size};
                            state_q <= e_MEM_UC_RD;
                        end else begin
                            uc_q    <= 1'b0;
                            size_q  <= SIZE_BLOCK;
                            state_q <= req.lru_dirty ? e_SEND_WB : e_MEM_RD;
                        end
                    end
                end
                e_SEND_WB: begin
                    if (lce_cmd_ready_i) state_q <= e_WAIT_WB;
                end
                e_WAIT_WB: begin
                    if (lce_resp_yumi_o) begin
                        if (resp.msg_type == RESP_WB) begin
                            wb_addr_q <= block_align(resp.addr);
                            data_q    <= resp.data;
                            state_q   <= e_MEM_WB;
                        end else begin
                            state_q   <= e_MEM_RD;
                        end
                    end
                end
                e_MEM_WB: begin
                    if (mem_cmd_ready_i) state_q <= e_MEM_RD;
                end
                e_MEM_RD, e_MEM_UC_RD: begin
                    if (mem_cmd_ready_i) state_q <= e_WAIT_MEM;
                end
                e_WAIT_MEM: begin
                    if (mem_resp_v_i && read_resp_ok) begin
                        data_q  <= mresp.data;
                        state_q <= e_SEND_DATA;
                    end
                end
                e_SEND_DATA: begin
                    if (lce_cmd_ready_i) state_q <= uc_q ? e_READY : e_WAIT_ACK;
                end
                e_WAIT_ACK: begin
                    if (lce_resp_yumi_o) state_q <= e_READY;
                end
                default: state_q <= e_READY;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Every memory response is either a write ack or the fill in flight, and
    // writeback responses only come in answer to a wb command.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(mem_resp_v_i && !mem_resp_yumi_o));
            assert (!(lce_resp_v_i && (state_q != e_WAIT_WB)
                      && ((resp.msg_type == RESP_WB) || (resp.msg_type == RESP_NULL_WB))));
            assert (!(lce_resp_v_i && (resp.msg_type == 2'd3)));
        end
    end
`endif

endmodule

// File: tb/tb_bp_cce_lce_req_responder.sv
module tb_bp_cce_lce_req_responder;

    localparam int REQ_W  = 112;
    localparam int RESP_W = 554;
    localparam int CMD_W  = 562;
    localparam int MEM_W  = 557;

    logic              clk_i;
    logic              reset_i;
    logic [2:0]        cce_id_i;
    logic [REQ_W-1:0]  lce_req_i;
    logic              lce_req_v_i;
    logic              lce_req_yumi_o;
    logic [RESP_W-1:0] lce_resp_i;
    logic              lce_resp_v_i;
    logic              lce_resp_yumi_o;
    logic [CMD_W-1:0]  lce_cmd_o;
    logic              lce_cmd_v_o;
    logic              lce_cmd_ready_i;
    logic [MEM_W-1:0]  mem_cmd_o;
    logic              mem_cmd_v_o;
    logic              mem_cmd_ready_i;
    logic [MEM_W-1:0]  mem_resp_i;
    logic              mem_resp_v_i;
    logic              mem_resp_yumi_o;

    bp_cce_lce_req_responder dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .cce_id_i        (cce_id_i),
        .lce_req_i       (lce_req_i),
        .lce_req_v_i     (lce_req_v_i),
        .lce_req_yumi_o  (lce_req_yumi_o),
        .lce_resp_i      (lce_resp_i),
        .lce_resp_v_i    (lce_resp_v_i),
        .lce_resp_yumi_o (lce_resp_yumi_o),
        .lce_cmd_o       (lce_cmd_o),
        .lce_cmd_v_o     (lce_cmd_v_o),
        .lce_cmd_ready_i (lce_cmd_ready_i),
        .mem_cmd_o       (mem_cmd_o),
        .mem_cmd_v_o     (mem_cmd_v_o),
        .mem_cmd_ready_i (mem_cmd_ready_i),
        .mem_resp_i      (mem_resp_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_yumi_o (mem_resp_yumi_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic [1:0] t, input logic dirty,
        input logic [2:0] way, input logic [1:0] sz, input logic [39:0] a, input logic [63:0] d);
        return {t, dirty, way, sz, a, d};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(input logic [1:0] t, input logic [39:0] a,
        input logic [511:0] d);
        return {t, a, d};
    endfunction

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [1:0] t, input logic [2:0] way,
        input logic [1:0] st, input logic [39:0] a, input logic [511:0] d);
        return {t, 3'd5, way, st, a, d};
    endfunction

    function automatic logic [MEM_W-1:0] mk_mem(input logic [1:0] t, input logic [2:0] sz,
        input logic [39:0] a, input logic [511:0] d);
        return {t, sz, a, d};
    endfunction

    logic [39:0]  a_addr, b_addr, v_addr, c_addr, e_addr, f_addr, g_addr, st_addr;
    logic [511:0] d1, d2, d3, d4, d5, uc_blk, uc_exp;
    logic [63:0]  st_data;

    initial begin
        a_addr = 40'h00_8000_0040;
        b_addr = 40'h00_8000_0080;
        v_addr = 40'h00_8000_1000;
        c_addr = 40'h00_8000_0100;
        e_addr = 40'h00_0000_0010;
        f_addr = 40'h00_8000_0200;
        g_addr = 40'h00_8000_0300;
        d1 = {8{64'h0123_4567_89AB_CDEF}};
        d2 = {8{64'hD1D1_0000_FFFF_2222}};
        d3 = {8{64'h3333_4444_5555_6666}};
        d4 = {8{64'hA5A5_5A5A_0F0F_F0F0}};
        d5 = {8{64'h7777_8888_9999_AAAA}};
        uc_blk = {{7{64'h1111_2222_3333_4444}}, 64'h0000_0000_DEAD_BEEF};
        uc_exp = {448'd0, 64'h0000_0000_DEAD_BEEF};

        reset_i = 1'b1;
        cce_id_i = 3'd5;
        lce_req_i = '0;  lce_req_v_i = 1'b0;
        lce_resp_i = '0; lce_resp_v_i = 1'b0;
        mem_resp_i = '0; mem_resp_v_i = 1'b0;
        lce_cmd_ready_i = 1'b1;
        mem_cmd_ready_i = 1'b1;

        // reset state, with a uc store and a mem response being offered
        @(negedge clk_i); @(negedge clk_i);
        lce_req_i = mk_req(2'd3, 1'b0, 3'd0, 2'd3, 40'h100, 64'h1);
        lce_req_v_i = 1'b1;
        mem_resp_i = mk_mem(2'd3, 3'd3, 40'h100, '0);
        mem_resp_v_i = 1'b1;
        #1;
        chk("rst_req_yumi", lce_req_yumi_o, 1'b0);
        chk("rst_resp_yumi", lce_resp_yumi_o, 1'b0);
        chk("rst_cmd_v", lce_cmd_v_o, 1'b0);
        chk("rst_mem_cmd_v", mem_cmd_v_o, 1'b0);
        chk("rst_mem_resp_yumi", mem_resp_yumi_o, 1'b0);
        lce_req_v_i = 1'b0;
        mem_resp_v_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);

        // clean load miss
        lce_req_i = mk_req(2'd0, 1'b0, 3'd2, 2'd0, a_addr, '0);
        lce_req_v_i = 1'b1;
        #1;
        chk("s1_req_yumi", lce_req_yumi_o, 1'b1);
        chk("s1_memcmd_v_t0", mem_cmd_v_o, 1'b0);
        @(negedge clk_i);
        lce_req_v_i = 1'b0;
        #1;
        chk("s1_memcmd_v_t1", mem_cmd_v_o, 1'b1);
        chk("s1_memcmd_rd", mem_cmd_o, mk_mem(2'd0, 3'd6, a_addr, '0));
        @(negedge clk_i);
        #1 chk("s1_memcmd_v_wait", mem_cmd_v_o, 1'b0);
        mem_resp_i = mk_mem(2'd0, 3'd6, a_addr, d1);
        mem_resp_v_i = 1'b1;
        #1 chk("s1_memresp_yumi", mem_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        #1;
        chk("s1_cmd_v", lce_cmd_v_o, 1'b1);
        chk("s1_cmd_data", lce_cmd_o, mk_cmd(2'd1, 3'd2, 2'd2, a_addr, d1));
        @(negedge clk_i);
        #1 chk("s1_cmd_v_after", lce_cmd_v_o, 1'b0);
        lce_resp_i = mk_resp(2'd0, a_addr + 40'h40, '0);
        lce_resp_v_i = 1'b1;
        #1 chk("s1_ack_wrong_addr", lce_resp_yumi_o, 1'b0);
        @(negedge clk_i);
        lce_resp_i = mk_resp(2'd0, a_addr, '0);
        #1 chk("s1_ack_yumi", lce_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_resp_v_i = 1'b0;

        // dirty store miss, victim in way 3
        lce_req_i = mk_req(2'd1, 1'b1, 3'd3, 2'd0, b_addr, '0);
        lce_req_v_i = 1'b1;
        #1 chk("s2_req_yumi", lce_req_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_req_v_i = 1'b0;
        #1;
        chk("s2_wb_v", lce_cmd_v_o, 1'b1);
        chk("s2_wb_cmd", lce_cmd_o, mk_cmd(2'd0, 3'd3, 2'd0, b_addr, '0));
        chk("s2_no_memcmd", mem_cmd_v_o, 1'b0);
        @(negedge clk_i);
        lce_resp_i = mk_resp(2'd0, b_addr, '0);
        lce_resp_v_i = 1'b1;
        #1 chk("s2_ack_in_wait_wb", lce_resp_yumi_o, 1'b0);
        @(negedge clk_i);
        lce_resp_i = mk_resp(2'd1, v_addr, d2);
        #1 chk("s2_resp_wb_yumi", lce_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_resp_v_i = 1'b0;
        #1;
        chk("s2_memwr_v", mem_cmd_v_o, 1'b1);
        chk("s2_memwr", mem_cmd_o, mk_mem(2'd1, 3'd6, v_addr, d2));
        @(negedge clk_i);
        #1 chk("s2_memrd", mem_cmd_o, mk_mem(2'd0, 3'd6, b_addr, '0));
        @(negedge clk_i);
        mem_resp_i = mk_mem(2'd1, 3'd6, v_addr, '0);
        mem_resp_v_i = 1'b1;
        #1 chk("s2_wr_ack_yumi", mem_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        mem_resp_i = mk_mem(2'd0, 3'd6, b_addr, d3);
        #1;
        chk("s2_still_wait_mem", lce_cmd_v_o, 1'b0);
        chk("s2_rd_yumi", mem_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        #1;
        chk("s2_data_v", lce_cmd_v_o, 1'b1);
        chk("s2_data_cmd", lce_cmd_o, mk_cmd(2'd1, 3'd3, 2'd2, b_addr, d3));
        @(negedge clk_i);
        lce_resp_i = mk_resp(2'd0, b_addr, '0);
        lce_resp_v_i = 1'b1;
        #1 chk("s2_ack_yumi", lce_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_resp_v_i = 1'b0;

        // five uncached stores with acks withheld
        for (int i = 0; i < 4; i++) begin
            st_addr = 40'h100 + 40'(8 * i);
            st_data = 64'hC0DE_0000_0000_0000 + 64'(i);
            lce_req_i = mk_req(2'd3, 1'b0, 3'd0, 2'd3, st_addr, st_data);
            lce_req_v_i = 1'b1;
            #1;
            chk($sformatf("s3_st%0d_yumi", i), lce_req_yumi_o, 1'b1);
            chk($sformatf("s3_st%0d_cmd", i), mem_cmd_o, mk_mem(2'd3, 3'd3, st_addr, {448'd0, st_data}));
            @(negedge clk_i);
        end
        st_addr = 40'h120;
        st_data = 64'hC0DE_0000_0000_0004;
        lce_req_i = mk_req(2'd3, 1'b0, 3'd0, 2'd3, st_addr, st_data);
        #1;
        chk("s3_st4_stall", lce_req_yumi_o, 1'b0);
        chk("s3_st4_no_cmd", mem_cmd_v_o, 1'b0);
        @(negedge clk_i);
        #1 chk("s3_st4_stall2", lce_req_yumi_o, 1'b0);
        mem_resp_i = mk_mem(2'd3, 3'd3, 40'h100, '0);
        mem_resp_v_i = 1'b1;
        #1;
        chk("s3_ack_yumi", mem_resp_yumi_o, 1'b1);
        chk("s3_st4_stall_ack_cyc", lce_req_yumi_o, 1'b0);
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        #1;
        chk("s3_st4_yumi", lce_req_yumi_o, 1'b1);
        chk("s3_st4_cmd", mem_cmd_o, mk_mem(2'd3, 3'd3, st_addr, {448'd0, st_data}));
        @(negedge clk_i);
        lce_req_v_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_resp_v_i = 1'b1;
            #1 chk($sformatf("s3_drain%0d", i), mem_resp_yumi_o, 1'b1);
            @(negedge clk_i);
        end
        mem_resp_v_i = 1'b0;
        lce_req_i = mk_req(2'd3, 1'b0, 3'd0, 2'd3, 40'h200, 64'h55);
        lce_req_v_i = 1'b1;
        #1 chk("s3_after_sat_yumi", lce_req_yumi_o, 1'b1);
        @(negedge clk_i);

        // cached miss blocked behind one outstanding store
        lce_req_i = mk_req(2'd0, 1'b0, 3'd1, 2'd0, c_addr, '0);
        #1 chk("s4_miss_blocked", lce_req_yumi_o, 1'b0);
        @(negedge clk_i);
        mem_resp_i = mk_mem(2'd3, 3'd3, 40'h200, '0);
        mem_resp_v_i = 1'b1;
        #1;
        chk("s4_miss_blocked_ack_cyc", lce_req_yumi_o, 1'b0);
        chk("s4_ack_yumi", mem_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        #1 chk("s4_miss_yumi", lce_req_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_req_v_i = 1'b0;
        #1 chk("s4_memrd", mem_cmd_o, mk_mem(2'd0, 3'd6, c_addr, '0));
        @(negedge clk_i);
        mem_resp_i = mk_mem(2'd0, 3'd6, c_addr, d4);
        mem_resp_v_i = 1'b1;
        #1 chk("s4_rd_yumi", mem_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        lce_cmd_ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("s4_hold_v%0d", k), lce_cmd_v_o, 1'b1);
            chk($sformatf("s4_hold_cmd%0d", k), lce_cmd_o, mk_cmd(2'd1, 3'd1, 2'd2, c_addr, d4));
            @(negedge clk_i);
        end
        lce_cmd_ready_i = 1'b1;
        #1 chk("s4_ready_v", lce_cmd_v_o, 1'b1);
        @(negedge clk_i);
        #1 chk("s4_advanced", lce_cmd_v_o, 1'b0);
        lce_resp_i = mk_resp(2'd0, c_addr, '0);
        lce_resp_v_i = 1'b1;
        #1 chk("s4_ack_yumi", lce_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_resp_v_i = 1'b0;

        // uncached 4-byte load
        lce_req_i = mk_req(2'd2, 1'b0, 3'd0, 2'd2, e_addr, '0);
        lce_req_v_i = 1'b1;
        #1 chk("s5_req_yumi", lce_req_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_req_v_i = 1'b0;
        #1 chk("s5_uc_rd", mem_cmd_o, mk_mem(2'd2, 3'd2, e_addr, '0));
        @(negedge clk_i);
        mem_resp_i = mk_mem(2'd2, 3'd2, e_addr, uc_blk);
        mem_resp_v_i = 1'b1;
        #1 chk("s5_resp_yumi", mem_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        #1 chk("s5_uc_data", lce_cmd_o, mk_cmd(2'd2, 3'd0, 2'd0, e_addr, uc_exp));
        @(negedge clk_i);

        // no ack awaited: the next miss is accepted right away, then reset mid-fill
        lce_req_i = mk_req(2'd0, 1'b0, 3'd4, 2'd0, f_addr, '0);
        lce_req_v_i = 1'b1;
        #1 chk("s6_req_yumi", lce_req_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_req_v_i = 1'b0;
        @(negedge clk_i);
        mem_resp_i = mk_mem(2'd0, 3'd6, f_addr, d5);
        mem_resp_v_i = 1'b1;
        lce_req_i = mk_req(2'd3, 1'b0, 3'd0, 2'd3, 40'h300, 64'h9);
        lce_req_v_i = 1'b1;
        #1 chk("s6_pre_rst_yumi", mem_resp_yumi_o, 1'b1);
        #1 reset_i = 1'b1;
        #1;
        chk("s6_rst_mem_resp_yumi", mem_resp_yumi_o, 1'b0);
        chk("s6_rst_req_yumi", lce_req_yumi_o, 1'b0);
        chk("s6_rst_mem_cmd_v", mem_cmd_v_o, 1'b0);
        chk("s6_rst_cmd_v", lce_cmd_v_o, 1'b0);
        chk("s6_rst_resp_yumi", lce_resp_yumi_o, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0;
        mem_resp_v_i = 1'b0;
        lce_req_v_i = 1'b0;
        @(negedge clk_i);
        lce_req_i = mk_req(2'd0, 1'b0, 3'd0, 2'd0, g_addr, '0);
        lce_req_v_i = 1'b1;
        #1 chk("s6_new_yumi", lce_req_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_req_v_i = 1'b0;
        #1 chk("s6_new_memrd", mem_cmd_o, mk_mem(2'd0, 3'd6, g_addr, '0));
        @(negedge clk_i);
        mem_resp_i = mk_mem(2'd0, 3'd6, g_addr, d5);
        mem_resp_v_i = 1'b1;
        #1 chk("s6_new_resp_yumi", mem_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        mem_resp_v_i = 1'b0;
        #1 chk("s6_new_data", lce_cmd_o, mk_cmd(2'd1, 3'd0, 2'd2, g_addr, d5));
        @(negedge clk_i);
        lce_resp_i = mk_resp(2'd0, g_addr, '0);
        lce_resp_v_i = 1'b1;
        #1 chk("s6_new_ack", lce_resp_yumi_o, 1'b1);
        @(negedge clk_i);
        lce_resp_v_i = 1'b0;
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
